// File: rtl/lfsr_stream_decrypt.sv
// rtl/lfsr_stream_decrypt.sv - LFSR keystream regenerator and ciphertext-to-plaintext byte stream decryptor
module lfsr_stream_decrypt #(
   parameter logic [15:0] MAGIC = 16'hA55A,
   parameter int          CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [63:0]      seed,
   input  logic             start,
   output logic             busy,
   output logic             seed_err,
   input  logic             ct_valid,
   output logic             ct_ready,
   input  logic [7:0]       ct_data,
   input  logic             ct_last,
   output logic             pt_valid,
   input  logic             pt_ready,
   output logic [7:0]       pt_data,
   output logic             pt_last,
   output logic [CNT_W-1:0] byte_count,
   output logic             hdr_ok,
   output logic             hdr_bad
);

   // All-ones is a fixed point of the XNOR feedback, so it can never be used as a seed
   localparam logic [63:0] LOCKUP_SEED = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   // One keystream shift: new bit enters at the bottom
   function automatic logic [63:0] lfsr_step(input logic [63:0] s);
      return {s[62:0], s[63] ~^ s[62] ~^ s[60] ~^ s[59]};
   endfunction

   // Eight shifts per byte, unrolled so a full key byte is produced each cycle
   function automatic logic [63:0] lfsr_step8(input logic [63:0] s);
      logic [63:0] t;
      t = s;
      for (int i = 0; i < 8; i++) begin
         t = lfsr_step(t);
      end
      return t;
   endfunction

   state_t           state_q, state_d;
   logic [63:0]      lfsr_q, lfsr_d;
   logic             seed_err_q, seed_err_d;
   logic             pt_valid_q, pt_valid_d;
   logic [7:0]       pt_data_q, pt_data_d;
   logic             pt_last_q, pt_last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hdr_done_q, hdr_done_d;
   logic             hdr_b0_ok_q, hdr_b0_ok_d;
   logic             hdr_ok_q, hdr_ok_d;
   logic             hdr_bad_q, hdr_bad_d;

   logic             ct_ready_c;
   logic             busy_c;
   logic             ct_fire;
   logic             pt_fire;
   logic             start_ok;
   logic             start_bad;
   logic [7:0]       plain_byte;

   assign ct_fire    = ct_valid && ct_ready_c;
   assign pt_fire    = pt_valid_q && pt_ready;
   assign start_ok   = (state_q == S_IDLE) && start && (seed != LOCKUP_SEED);
   assign start_bad  = (state_q == S_IDLE) && start && (seed == LOCKUP_SEED);
   assign plain_byte = ct_data ^ lfsr_q[7:0];

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: RUN until the last ciphertext byte is taken, FLUSH until it is consumed
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (ct_fire && ct_last) begin
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (pt_fire) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State outputs: accept a byte only when the single output slot is free or draining this cycle
   always_comb begin
      ct_ready_c = 1'b0;
      busy_c     = 1'b0;
      case (state_q)
         S_RUN: begin
            ct_ready_c = !pt_valid_q || pt_ready;
            busy_c     = 1'b1;
         end
         S_FLUSH: begin
            busy_c     = 1'b1;
         end
         default: begin
            ct_ready_c = 1'b0;
            busy_c     = 1'b0;
         end
      endcase
   end

   // Keystream register: load on start, advance one byte per accepted ciphertext byte
   always_comb begin
      lfsr_d = lfsr_q;
      if (start_ok) begin
         lfsr_d = seed;
      end else if (ct_fire) begin
         lfsr_d = lfsr_step8(lfsr_q);
      end
   end

   // Seed error flag: updated only by starts taken in IDLE
   always_comb begin
      seed_err_d = seed_err_q;
      if (start_bad) begin
         seed_err_d = 1'b1;
      end else if (start_ok) begin
         seed_err_d = 1'b0;
      end
   end

   // Byte counter: cleared per message, saturates rather than wrapping
   always_comb begin
      cnt_d = cnt_q;
      if (start_ok) begin
         cnt_d = '0;
      end else if (ct_fire && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Output slot: a new byte overwrites in the same cycle the old one drains
   always_comb begin
      pt_valid_d = pt_valid_q;
      pt_data_d  = pt_data_q;
      pt_last_d  = pt_last_q;
      if (ct_fire) begin
         pt_valid_d = 1'b1;
         pt_data_d  = plain_byte;
         pt_last_d  = ct_last;
      end else if (pt_fire) begin
         pt_valid_d = 1'b0;
      end
   end

   // Header check: remember byte 0's match, decide on byte 1 (or on a lone last byte 0)
   always_comb begin
      hdr_done_d  = hdr_done_q;
      hdr_b0_ok_d = hdr_b0_ok_q;
      hdr_ok_d    = 1'b0;
      hdr_bad_d   = 1'b0;
      if (start_ok) begin
         hdr_done_d  = 1'b0;
         hdr_b0_ok_d = 1'b0;
      end else if (ct_fire && !hdr_done_q) begin
         if (cnt_q == '0) begin
            hdr_b0_ok_d = (plain_byte == MAGIC[15:8]);
            if (ct_last) begin
               hdr_bad_d  = 1'b1;
               hdr_done_d = 1'b1;
            end
         end else begin
            if (hdr_b0_ok_q && (plain_byte == MAGIC[7:0])) begin
               hdr_ok_d  = 1'b1;
            end else begin
               hdr_bad_d = 1'b1;
            end
            hdr_done_d = 1'b1;
         end
      end
   end

   // Datapath registers; reset discards any pending output byte
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q      <= '0;
         seed_err_q  <= 1'b0;
         pt_valid_q  <= 1'b0;
         pt_data_q   <= 8'h00;
         pt_last_q   <= 1'b0;
         cnt_q       <= '0;
         hdr_done_q  <= 1'b0;
         hdr_b0_ok_q <= 1'b0;
         hdr_ok_q    <= 1'b0;
         hdr_bad_q   <= 1'b0;
      end else begin
         lfsr_q      <= lfsr_d;
         seed_err_q  <= seed_err_d;
         pt_valid_q  <= pt_valid_d;
         pt_data_q   <= pt_data_d;
         pt_last_q   <= pt_last_d;
         cnt_q       <= cnt_d;
         hdr_done_q  <= hdr_done_d;
         hdr_b0_ok_q <= hdr_b0_ok_d;
         hdr_ok_q    <= hdr_ok_d;
         hdr_bad_q   <= hdr_bad_d;
      end
   end

   assign busy       = busy_c;
   assign ct_ready   = ct_ready_c;
   assign seed_err   = seed_err_q;
   assign pt_valid   = pt_valid_q;
   assign pt_data    = pt_data_q;
   assign pt_last    = pt_last_q;
   assign byte_count = cnt_q;
   assign hdr_ok     = hdr_ok_q;
   assign hdr_bad    = hdr_bad_q;

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// tb/tb_lfsr_stream_decrypt.sv - directed self-checking bench for lfsr_stream_decrypt
module tb_lfsr_stream_decrypt;

   logic        clk;
   logic        reset;
   logic [63:0] seed;
   logic        start;
   logic        busy;
   logic        seed_err;
   logic        ct_valid;
   logic        ct_ready;
   logic [7:0]  ct_data;
   logic        ct_last;
   logic        pt_valid;
   logic        pt_ready;
   logic [7:0]  pt_data;
   logic        pt_last;
   logic [15:0] byte_count;
   logic        hdr_ok;
   logic        hdr_bad;

   lfsr_stream_decrypt #(.MAGIC(16'hA55A), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .seed       (seed),
      .start      (start),
      .busy       (busy),
      .seed_err   (seed_err),
      .ct_valid   (ct_valid),
      .ct_ready   (ct_ready),
      .ct_data    (ct_data),
      .ct_last    (ct_last),
      .pt_valid   (pt_valid),
      .pt_ready   (pt_ready),
      .pt_data    (pt_data),
      .pt_last    (pt_last),
      .byte_count (byte_count),
      .hdr_ok     (hdr_ok),
      .hdr_bad    (hdr_bad)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [8:0]  got_q[$];
   int          ok_cnt = 0;
   int          bad_cnt = 0;
   logic [7:0]  hdr_pt = 8'h00;
   logic        chk_fall = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: collect plaintext handshakes and header pulses, check busy falls after the last byte
   always @(negedge clk) begin
      if (chk_fall) begin
         check("busy_fall", 32'(busy), 32'd0);
         chk_fall = 1'b0;
      end
      if (hdr_ok) begin
         ok_cnt++;
         hdr_pt = pt_data;
      end
      if (hdr_bad) begin
         bad_cnt++;
         hdr_pt = pt_data;
      end
      if (pt_valid && pt_ready && !reset) begin
         got_q.push_back({pt_last, pt_data});
         if (pt_last) begin
            check("busy_at_last", 32'(busy), 32'd1);
            chk_fall = 1'b1;
         end
      end
   end

   task automatic clear_obs();
      got_q.delete();
      ok_cnt  = 0;
      bad_cnt = 0;
      hdr_pt  = 8'h00;
   endtask

   task automatic do_start(input logic [63:0] s);
      seed  = s;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Present one ciphertext byte and hold it until accepted (bounded)
   task automatic push(input logic [7:0] d, input logic l);
      int n;
      ct_valid = 1'b1;
      ct_data  = d;
      ct_last  = l;
      n = 0;
      @(negedge clk);
      while (!ct_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ct_ready) check("push_timeout", 32'(ct_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_stream(input string tag, input int n,
                               input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2);
      logic [8:0] e [3];
      e[0] = e0;
      e[1] = e1;
      e[2] = e2;
      check({tag, "_count"}, 32'(got_q.size()), 32'(n));
      for (int i = 0; i < n && i < got_q.size(); i++) begin
         check({tag, "_byte"}, 32'(got_q[i]), 32'(e[i]));
      end
   endtask

   initial begin
      reset    = 1'b1;
      seed     = '0;
      start    = 1'b0;
      ct_valid = 1'b0;
      ct_data  = 8'h00;
      ct_last  = 1'b0;
      pt_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy",     32'(busy),       32'd0);
      check("rst_seed_err", 32'(seed_err),   32'd0);
      check("rst_ct_ready", 32'(ct_ready),   32'd0);
      check("rst_pt_valid", 32'(pt_valid),   32'd0);
      check("rst_pt_data",  32'(pt_data),    32'h00);
      check("rst_pt_last",  32'(pt_last),    32'd0);
      check("rst_count",    32'(byte_count), 32'd0);
      check("rst_hdr",      32'({hdr_ok, hdr_bad}), 32'd0);
      @(posedge clk);
      #1;

      // Magic header, full throughput: A5 A5 00 -> A5 5A FF
      clear_obs();
      do_start(64'h0);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_ct_ready", 32'(ct_ready), 32'd1);
      push(8'hA5, 1'b0);
      push(8'hA5, 1'b0);
      push(8'h00, 1'b1);
      ct_valid = 1'b0;
      wait_idle();
      check_stream("t1", 3, 9'h0A5, 9'h05A, 9'h1FF);
      check("t1_hdr_ok",  32'(ok_cnt),  32'd1);
      check("t1_hdr_bad", 32'(bad_cnt), 32'd0);
      check("t1_hdr_at",  32'(hdr_pt),  32'h5A);
      check("t1_count",   32'(byte_count), 32'd3);

      // Header mismatch, plus a start while busy that must be ignored
      clear_obs();
      do_start(64'h0);
      push(8'h00, 1'b0);
      ct_valid = 1'b0;
      do_start(64'hFFFF_FFFF_FFFF_FFFF);
      check("t2_seed_err", 32'(seed_err), 32'd0);
      check("t2_busy", 32'(busy), 32'd1);
      push(8'h00, 1'b1);
      ct_valid = 1'b0;
      wait_idle();
      check_stream("t2", 2, 9'h000, 9'h1FF, 9'h000);
      check("t2_hdr_ok",  32'(ok_cnt),  32'd0);
      check("t2_hdr_bad", 32'(bad_cnt), 32'd1);

      // Backpressure: one byte taken, ct_ready held off while output slot is stuck
      clear_obs();
      pt_ready = 1'b0;
      do_start(64'h0);
      push(8'hA5, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t3_ct_ready_low", 32'(ct_ready), 32'd0);
      end
      check("t3_count_held", 32'(byte_count), 32'd1);
      @(posedge clk);
      #1 pt_ready = 1'b1;
      push(8'hA5, 1'b0);
      push(8'h00, 1'b1);
      ct_valid = 1'b0;
      wait_idle();
      check_stream("t3", 3, 9'h0A5, 9'h05A, 9'h1FF);
      check("t3_hdr_ok", 32'(ok_cnt), 32'd1);

      // Lockup seed rejected, then a good seed recovers; single-byte message
      clear_obs();
      do_start(64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      check("t4_seed_err", 32'(seed_err), 32'd1);
      check("t4_busy",     32'(busy),     32'd0);
      check("t4_ct_ready", 32'(ct_ready), 32'd0);
      @(posedge clk);
      #1;
      do_start(64'h0);
      check("t4_seed_err_clr", 32'(seed_err), 32'd0);
      check("t4_busy_run",     32'(busy),     32'd1);
      push(8'h12, 1'b1);
      ct_valid = 1'b0;
      wait_idle();
      check_stream("t5", 1, 9'h112, 9'h000, 9'h000);
      check("t5_hdr_bad", 32'(bad_cnt), 32'd1);
      check("t5_hdr_ok",  32'(ok_cnt),  32'd0);
      check("t5_hdr_at",  32'(hdr_pt),  32'h12);

      // Reset mid-message, then restart reproduces the keystream from the start
      do_start(64'h0);
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      ct_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("t6_pt_valid", 32'(pt_valid),   32'd0);
      check("t6_count",    32'(byte_count), 32'd0);
      check("t6_busy",     32'(busy),       32'd0);
      @(posedge clk);
      #1;
      clear_obs();
      do_start(64'h0);
      push(8'h00, 1'b0);
      push(8'h00, 1'b1);
      ct_valid = 1'b0;
      wait_idle();
      check_stream("t6", 2, 9'h000, 9'h1FF, 9'h000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lfsr_stream_decrypt.md
# lfsr_stream_decrypt

Receive-side counterpart of the 64-bit LFSR keystream generator. It loads a 64-bit seed, regenerates the same XNOR-feedback LFSR keystream, and XORs it byte-by-byte onto an incoming ciphertext stream to recover plaintext. It sits between the ciphertext byte source (UART/memory reader) and the plaintext consumer. A two-byte magic-header check lets a seed-search controller reject wrong seeds early.

## Interface

Parameters:
- MAGIC, 16'hA55A, expected first two plaintext bytes; byte 0 = MAGIC[15:8], byte 1 = MAGIC[7:0]
- CNT_W, 16, width of byte_count

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- seed  in  64  keystream seed, sampled on accepted start
- start  in  1  load seed and begin a message
- busy  out  1  high in RUN and FLUSH
- seed_err  out  1  sticky; set when start carries lockup seed; cleared by the next accepted start
- ct_valid  in  1  ciphertext byte valid
- ct_ready  out  1  block can accept a ciphertext byte
- ct_data  in  8  ciphertext byte
- ct_last  in  1  marks final ciphertext byte
- pt_valid  out  1  plaintext byte valid
- pt_ready  in  1  consumer accepts plaintext
- pt_data  out  8  plaintext byte
- pt_last  out  1  marks final plaintext byte
- byte_count  out  CNT_W  bytes accepted in current message
- hdr_ok  out  1  one-cycle pulse: header matched
- hdr_bad  out  1  one-cycle pulse: header mismatched or message too short

## Operation

- LFSR step: s' = {s[62:0], s[63] ~^ s[62] ~^ s[60] ~^ s[59]}. step8 = eight successive steps, computed combinationally in one cycle.
- Lockup seed: 64'hFFFF_FFFF_FFFF_FFFF.
- States:
  - IDLE: ct_ready=0. On start:
    - If seed is the lockup value: set seed_err and stay in IDLE.
    - Otherwise: lfsr<=seed, byte_count<=0, seed_err<=0, go to RUN.
  - RUN: ct_ready = !pt_valid || pt_ready.
  - On ct handshake (ct_valid && ct_ready):
    - pt_data <= ct_data ^ lfsr[7:0]
    - pt_last <= ct_last
    - pt_valid <= 1
    - lfsr <= step8(lfsr)
    - byte_count <= byte_count + 1, saturating at all-ones
  - If the accepted byte has ct_last=1: go to FLUSH.
  - FLUSH: ct_ready=0. When the pending pt byte handshakes (pt_valid && pt_ready), go to IDLE.
- Output register: single entry.
  - pt_valid clears on pt handshake unless a new ct byte is accepted in the same cycle; in that case it stays 1 with the new data.
  - Full throughput: 1 byte/cycle when pt_ready is held high.
- Header check (once per message):
  - Computed from the plaintext bytes at index 0 and 1.
  - Decided in the cycle after byte index 1 is accepted:
    - Both bytes match MAGIC: hdr_ok pulses.
    - Either byte mismatches: hdr_bad pulses.
  - A message ending at byte 0 (ct_last on the first byte) pulses hdr_bad the cycle after acceptance.
  - No further pulses until the next start.
- start while busy is ignored: no reload, no seed_err change.
- Reset mid-message: state returns to IDLE immediately and the pending output is discarded.

## Timing

- Reset values:
  - State IDLE, lfsr 0, busy 0, seed_err 0, ct_ready 0.
  - pt_valid 0, pt_data 0x00, pt_last 0, byte_count 0, hdr_ok 0, hdr_bad 0.
- Start to first ct_ready: start sampled at edge N; ct_ready=1 in cycle N+1.
- Latency: ct handshake at edge N produces pt_valid/pt_data from N+1 (one cycle).
- hdr_ok/hdr_bad: high for exactly the cycle in which byte 1's (or a lone byte 0's) pt_valid first rises.
- busy: falls in the cycle after the last pt handshake.
- ct_ready is a function of registered state and pt_ready only; it has no dependence on ct_valid.
- Keystream with seed 0: key bytes 0x00, 0xFF, 0xFF, ...
  - step8(0) = 0x00000000_000000FF
  - step8 of that = 0x00000000_0000FFFF

## Test plan

- Seed 0, MAGIC A55A, ct = A5, A5, 00 (last on third), pt_ready=1:
  - pt = A5, 5A, FF; pt_last on the third byte.
  - hdr_ok pulses once; byte_count ends at 3; busy drops after the third pt handshake.
- Seed 0, ct = 00, 00 (last):
  - pt = 00, FF; hdr_bad pulses and hdr_ok never pulses.
- Backpressure: pt_ready held low for 5 cycles with ct_valid high.
  - Exactly one byte is accepted; ct_ready stays 0 until pt_ready rises.
  - No data lost or duplicated; the ordering of the seed-0 A5/A5 case holds.
- start with seed all-ones:
  - seed_err=1, busy stays 0, ct_ready stays 0.
  - A subsequent start with seed 0 clears seed_err and enters RUN.
- Single byte ct 0x12 with last, seed 0:
  - pt 0x12, pt_last=1, hdr_bad pulse, return to IDLE.
- reset asserted mid-message after 2 bytes:
  - Next cycle pt_valid=0, byte_count=0, state IDLE.
  - A restart with the same seed reproduces key bytes 00, FF.
